data_mem_lsu: RTL and testbench

Load/store initiator that drives the ZCore data memory interface: data_mem_write_*_o, data_mem_read_*_o and data_mem_read_data_i.
- Accepts one load or store request at a time from the execute stage.
- Issues word-aligned memory accesses and returns sign/zero-extended load data.
- Performs read-modify-write for byte and halfword stores, because the data memory is word-writable only.
- Rejects misaligned and out-of-range accesses without touching memory.

---
 rtl/data_mem_lsu.sv | 189 ++++++++++++++++++
 tb/tb_data_mem_lsu.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_lsu.sv
// data_mem_lsu: load/store initiator for the ZCore word-writable data memory.
// Sub-word stores use read-modify-write; bad requests are answered without a memory strobe.
module data_mem_lsu #(
    parameter int unsigned DM_WIDTH = 32,
    parameter int unsigned DM_BASE  = 295200,
    parameter int unsigned DM_WORDS = 101
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_we_i,
    input  logic [1:0]          req_size_i,
    input  logic                req_unsigned_i,
    input  logic [DM_WIDTH-1:0] req_addr_i,
    input  logic [DM_WIDTH-1:0] req_wdata_i,
    output logic                resp_valid_o,
    output logic [DM_WIDTH-1:0] resp_rdata_o,
    output logic                resp_err_o,
    output logic                data_mem_write_en_o,
    output logic [DM_WIDTH-1:0] data_mem_write_addr_o,
    output logic [DM_WIDTH-1:0] data_mem_write_data_o,
    output logic                data_mem_read_en_o,
    output logic [DM_WIDTH-1:0] data_mem_read_addr_o,
    input  logic [DM_WIDTH-1:0] data_mem_read_data_i
);
    localparam int unsigned W = DM_WIDTH;
    localparam logic [W-1:0] ADDR_LO = W'(DM_BASE);
    localparam logic [W-1:0] ADDR_HI = W'(DM_BASE + 4 * DM_WORDS - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LD_RD   = 3'd1;
    localparam logic [2:0] S_LD_CAP  = 3'd2;
    localparam logic [2:0] S_RMW_RD  = 3'd3;
    localparam logic [2:0] S_RMW_MRG = 3'd4;
    localparam logic [2:0] S_ST_WR   = 3'd5;
    localparam logic [2:0] S_RESP    = 3'd6;

    logic [2:0]   state_q, state_d;
    logic [1:0]   size_q, size_d;
    logic         uns_q, uns_d;
    logic [W-1:0] addr_q, addr_d;
    logic [15:0]  wdata_q, wdata_d;

    logic         ready_q, ready_d;
    logic         resp_valid_q, resp_valid_d;
    logic         resp_err_q, resp_err_d;
    logic [W-1:0] resp_rdata_q, resp_rdata_d;
    logic         wr_en_q, wr_en_d;
    logic [W-1:0] wr_addr_q, wr_addr_d;
    logic [W-1:0] wr_data_q, wr_data_d;
    logic         rd_en_q, rd_en_d;
    logic [W-1:0] rd_addr_q, rd_addr_d;

    logic         acc_err;
    logic [7:0]   lane_b;
    logic [15:0]  lane_h;
    logic [W-1:0] ld_ext;
    logic [W-1:0] st_merge;
    logic [W-1:0] mem_addr;

    // Load lane select and extension from the word returned by memory
    always_comb begin
        lane_b = 8'h00;
        case (addr_q[1:0])
            2'd0:    lane_b = data_mem_read_data_i[7:0];
            2'd1:    lane_b = data_mem_read_data_i[15:8];
            2'd2:    lane_b = data_mem_read_data_i[23:16];
            default: lane_b = data_mem_read_data_i[31:24];
        endcase
        lane_h = addr_q[1] ? data_mem_read_data_i[31:16] : data_mem_read_data_i[15:0];
        case (size_q)
            2'b00:   ld_ext = uns_q ? {{(W-8){1'b0}}, lane_b} : {{(W-8){lane_b[7]}}, lane_b};
            2'b01:   ld_ext = uns_q ? {{(W-16){1'b0}}, lane_h} : {{(W-16){lane_h[15]}}, lane_h};
            default: ld_ext = data_mem_read_data_i;
        endcase
    end

    // Store merge: replace only the addressed byte/half lane
    always_comb begin
        st_merge = data_mem_read_data_i;
        if (size_q == 2'b00) begin
            case (addr_q[1:0])
                2'd0:    st_merge[7:0]   = wdata_q[7:0];
                2'd1:    st_merge[15:8]  = wdata_q[7:0];
                2'd2:    st_merge[23:16] = wdata_q[7:0];
                default: st_merge[31:24] = wdata_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            st_merge[31:16] = wdata_q;
        end else begin
            st_merge[15:0] = wdata_q;
        end
    end

    always_comb begin
        state_d = state_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        acc_err = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    size_d  = req_size_i;
                    uns_d   = req_unsigned_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i[15:0];
                    acc_err = (req_size_i == 2'b11)
                           || ((req_size_i == 2'b01) && req_addr_i[0])
                           || ((req_size_i == 2'b10) && (req_addr_i[1:0] != 2'b00))
                           || (req_addr_i < ADDR_LO)
                           || (req_addr_i > ADDR_HI);
                    if (acc_err)                   state_d = S_RESP;
                    else if (!req_we_i)            state_d = S_LD_RD;
                    else if (req_size_i == 2'b10)  state_d = S_ST_WR;
                    else                           state_d = S_RMW_RD;
                end
            end
            S_LD_RD:   state_d = S_LD_CAP;
            S_LD_CAP:  state_d = S_RESP;
            S_RMW_RD:  state_d = S_RMW_MRG;
            S_RMW_MRG: state_d = S_ST_WR;
            S_ST_WR:   state_d = S_RESP;
            default:   state_d = S_IDLE;
        endcase

        // Outputs are registered from the upcoming state so each strobe lines up with its state
        mem_addr     = {addr_d[W-1:2], 2'b00};
        ready_d      = (state_d == S_IDLE);
        rd_en_d      = (state_d == S_LD_RD) || (state_d == S_RMW_RD);
        rd_addr_d    = rd_en_d ? mem_addr : '0;
        wr_en_d      = (state_d == S_ST_WR);
        wr_addr_d    = wr_en_d ? mem_addr : '0;
        wr_data_d    = '0;
        if (wr_en_d) begin
            wr_data_d = (state_q == S_RMW_MRG) ? st_merge : req_wdata_i;
        end
        resp_valid_d = (state_d == S_RESP);
        resp_err_d   = (state_d == S_RESP) && (state_q == S_IDLE);
        resp_rdata_d = (state_q == S_LD_CAP) ? ld_ext : '0;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= S_IDLE;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= 16'h0000;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
        end else begin
            state_q      <= state_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            rd_en_q      <= rd_en_d;
            rd_addr_q    <= rd_addr_d;
        end
    end

    assign req_ready_o           = ready_q;
    assign resp_valid_o          = resp_valid_q;
    assign resp_err_o            = resp_err_q;
    assign resp_rdata_o          = resp_rdata_q;
    assign data_mem_write_en_o   = wr_en_q;
    assign data_mem_write_addr_o = wr_addr_q;
    assign data_mem_write_data_o = wr_data_q;
    assign data_mem_read_en_o    = rd_en_q;
    assign data_mem_read_addr_o  = rd_addr_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Self-checking bench for data_mem_lsu: directed vector table, multi-cycle corner sequences,
// and random traffic against a byte-array reference model of the data memory.
module tb_data_mem_lsu;
    localparam int unsigned DM_BASE  = 295200;
    localparam int unsigned DM_WORDS = 101;
    localparam int unsigned NBYTES   = 4 * DM_WORDS;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        req_valid_i, req_ready_o, req_we_i, req_unsigned_i;
    logic [1:0]  req_size_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic        resp_valid_o, resp_err_o;
    logic [31:0] resp_rdata_o;
    logic        data_mem_write_en_o, data_mem_read_en_o;
    logic [31:0] data_mem_write_addr_o, data_mem_write_data_o;
    logic [31:0] data_mem_read_addr_o, data_mem_read_data_i;

    int total = 0;
    int bad   = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;

    logic [31:0] mem_w [DM_WORDS];
    logic [7:0]  ref_b [NBYTES];

    data_mem_lsu #(.DM_WIDTH(32), .DM_BASE(DM_BASE), .DM_WORDS(DM_WORDS)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
        .data_mem_write_en_o(data_mem_write_en_o), .data_mem_write_addr_o(data_mem_write_addr_o),
        .data_mem_write_data_o(data_mem_write_data_o), .data_mem_read_en_o(data_mem_read_en_o),
        .data_mem_read_addr_o(data_mem_read_addr_o), .data_mem_read_data_i(data_mem_read_data_i)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int word_index(input logic [31:0] a, output logic ok);
        longint off;
        off = longint'(a) - longint'(DM_BASE);
        ok  = (a[1:0] == 2'b00) && (off >= 0) && (off < longint'(NBYTES));
        return ok ? int'(off / 4) : 0;
    endfunction

    // Memory responder: read data appears the cycle after the strobe, garbage otherwise
    always @(posedge clk_in) begin : responder
        int  idx;
        logic ok;
        if (data_mem_read_en_o || data_mem_write_en_o)
            chk("strobe_exclusive", 32'(data_mem_read_en_o & data_mem_write_en_o), 32'd0);
        if (data_mem_read_en_o) begin
            rd_cnt++;
            idx = word_index(data_mem_read_addr_o, ok);
            chk("rd_addr_legal", 32'(ok), 32'd1);
            data_mem_read_data_i <= ok ? mem_w[idx] : 32'hBAD0BAD0;
        end else begin
            data_mem_read_data_i <= $urandom();
        end
        if (data_mem_write_en_o) begin
            wr_cnt++;
            idx = word_index(data_mem_write_addr_o, ok);
            chk("wr_addr_legal", 32'(ok), 32'd1);
            if (ok) mem_w[idx] = data_mem_write_data_o;
        end
    end

    task automatic set_word(input int w, input logic [31:0] v);
        mem_w[w] = v;
        for (int i = 0; i < 4; i++) ref_b[4*w+i] = 8'(v >> (8*i));
    endtask

    // Reference model over a byte array; updates the model on successful stores
    task automatic model(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output logic [31:0] rd, output logic er,
                         output int nrd, output int nwr);
        int nb;
        longint off;
        logic [31:0] v;
        nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        off = longint'(a) - longint'(DM_BASE);
        er  = (sz == 2'd3) || ((a % 32'(nb)) != 0) || (off < 0) || (off > longint'(NBYTES) - 1);
        rd  = 32'd0;
        if (er) begin
            lat = 1; nrd = 0; nwr = 0;
        end else if (!we) begin
            lat = 3; nrd = 1; nwr = 0;
            v = 32'd0;
            for (int i = 0; i < nb; i++) v = v | (32'(ref_b[int'(off)+i]) << (8*i));
            if (!uns && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8*nb)) - 32'd1);
            rd = v;
        end else begin
            for (int i = 0; i < nb; i++) ref_b[int'(off)+i] = 8'(wd >> (8*i));
            lat = (nb == 4) ? 2 : 4;
            nrd = (nb == 4) ? 0 : 1;
            nwr = 1;
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
        req_valid_i = 1'b1; req_we_i = we; req_size_i = sz;
        req_unsigned_i = uns; req_addr_i = a; req_wdata_i = wd;
    endtask

    task automatic wait_ready();
        int guard = 0;
        while (!req_ready_o && guard < 50) begin @(posedge clk_in); #1; guard++; end
        if (guard >= 50) chk("accept_timeout", 32'(req_ready_o), 32'd1);
    endtask

    // Issue one request and measure latency, response and strobe counts
    task automatic run_txn(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd,
                           output int lat, output logic [31:0] rd, output logic er,
                           output int nrd, output int nwr);
        int rd0, wr0;
        drive(we, sz, uns, a, wd);
        wait_ready();
        rd0 = rd_cnt; wr0 = wr_cnt;
        @(posedge clk_in); #1;
        req_valid_i = 1'b0;
        lat = 1;
        while (!resp_valid_o && lat < 30) begin @(posedge clk_in); #1; lat++; end
        rd = resp_rdata_o; er = resp_err_o;
        nrd = rd_cnt - rd0; nwr = wr_cnt - wr0;
    endtask

    task automatic chk_txn(input string tag, input int lat, input logic [31:0] rd, input logic er,
                           input int nrd, input int nwr, input int e_lat, input logic [31:0] e_rd,
                           input logic e_er, input int e_nrd, input int e_nwr);
        chk({tag, "_lat"},   32'(lat), 32'(e_lat));
        chk({tag, "_rdata"}, rd, e_rd);
        chk({tag, "_err"},   32'(er), 32'(e_er));
        chk({tag, "_nrd"},   32'(nrd), 32'(e_nrd));
        chk({tag, "_nwr"},   32'(nwr), 32'(e_nwr));
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ready"}, 32'(req_ready_o), 32'd1);
        chk({tag, "_rvalid"}, 32'(resp_valid_o), 32'd0);
        chk({tag, "_rerr"}, 32'(resp_err_o), 32'd0);
        chk({tag, "_rdata"}, resp_rdata_o, 32'd0);
        chk({tag, "_strobes"}, 32'({data_mem_read_en_o, data_mem_write_en_o}), 32'd0);
        chk({tag, "_addrs"}, data_mem_read_addr_o | data_mem_write_addr_o, 32'd0);
        chk({tag, "_wdata"}, data_mem_write_data_o, 32'd0);
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wd;
        int          lat;
        logic [31:0] rdata;
        logic        err;
        int          nrd;
        int          nwr;
    } vec_t;

    vec_t vecs [16];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit, total=%0d", total);
        $fatal(1);
    end

    initial begin : main
        int lat, nrd, nwr, e_lat, e_nrd, e_nwr, rd0, wr0, r;
        logic [31:0] rd, e_rd, a, wd;
        logic er, e_er, uns, we, seen_resp;
        logic [1:0] sz;

        vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'd295200, 32'hDEADBEEF, 2, 32'h0,        1'b0, 0, 1};
        vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'd295200, 32'h0,        3, 32'hDEADBEEF, 1'b0, 1, 0};
        vecs[2]  = '{1'b0, 2'd0, 1'b0, 32'd295207, 32'h0,        3, 32'hFFFFFF80, 1'b0, 1, 0};
        vecs[3]  = '{1'b0, 2'd0, 1'b1, 32'd295207, 32'h0,        3, 32'h00000080, 1'b0, 1, 0};
        vecs[4]  = '{1'b0, 2'd1, 1'b0, 32'd295204, 32'h0,        3, 32'h00007F00, 1'b0, 1, 0};
        vecs[5]  = '{1'b0, 2'd1, 1'b1, 32'd295206, 32'h0,        3, 32'h00008081, 1'b0, 1, 0};
        vecs[6]  = '{1'b1, 2'd0, 1'b0, 32'd295209, 32'h000000AA, 4, 32'h0,        1'b0, 1, 1};
        vecs[7]  = '{1'b0, 2'd2, 1'b0, 32'd295208, 32'h0,        3, 32'h1122AA44, 1'b0, 1, 0};
        vecs[8]  = '{1'b1, 2'd1, 1'b0, 32'd295210, 32'h0000BEEF, 4, 32'h0,        1'b0, 1, 1};
        vecs[9]  = '{1'b0, 2'd2, 1'b0, 32'd295208, 32'h0,        3, 32'hBEEFAA44, 1'b0, 1, 0};
        vecs[10] = '{1'b1, 2'd1, 1'b0, 32'd295201, 32'h1234,     1, 32'h0,        1'b1, 0, 0};
        vecs[11] = '{1'b0, 2'd2, 1'b0, 32'd295202, 32'h0,        1, 32'h0,        1'b1, 0, 0};
        vecs[12] = '{1'b0, 2'd3, 1'b0, 32'd295200, 32'h0,        1, 32'h0,        1'b1, 0, 0};
        vecs[13] = '{1'b0, 2'd2, 1'b0, 32'd295604, 32'h0,        1, 32'h0,        1'b1, 0, 0};
        vecs[14] = '{1'b0, 2'd2, 1'b0, 32'd295600, 32'h0,        3, 32'h0BADF00D, 1'b0, 1, 0};
        vecs[15] = '{1'b1, 2'd2, 1'b0, 32'd295196, 32'h5A5A5A5A, 1, 32'h0,        1'b1, 0, 0};

        for (int w = 0; w < int'(DM_WORDS); w++) set_word(w, $urandom());
        set_word(1, 32'h80817F00);
        set_word(2, 32'h11223344);
        set_word(100, 32'h0BADF00D);

        rst_in = 1'b1;
        drive(1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        req_valid_i = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        chk_idle_outputs("reset");
        rst_in = 1'b0;

        for (int i = 0; i < 16; i++) begin
            model(vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd,
                  e_lat, e_rd, e_er, e_nrd, e_nwr);
            run_txn(vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd,
                    lat, rd, er, nrd, nwr);
            chk_txn($sformatf("vec%0d", i), lat, rd, er, nrd, nwr,
                    vecs[i].lat, vecs[i].rdata, vecs[i].err, vecs[i].nrd, vecs[i].nwr);
        end

        // Backpressure: a second request held on the bus while the first is in flight
        model(1'b1, 2'd2, 1'b0, 32'd295212, 32'h5555AAAA, e_lat, e_rd, e_er, e_nrd, e_nwr);
        drive(1'b1, 2'd2, 1'b0, 32'd295212, 32'h5555AAAA);
        wait_ready();
        rd0 = rd_cnt; wr0 = wr_cnt;
        @(posedge clk_in); #1;
        drive(1'b0, 2'd2, 1'b0, 32'd295212, 32'h0);
        chk("bp_ready_c1", 32'(req_ready_o), 32'd0);
        chk("bp_wren_c1", 32'(data_mem_write_en_o), 32'd1);
        chk("bp_waddr_c1", data_mem_write_addr_o, 32'd295212);
        chk("bp_wdata_c1", data_mem_write_data_o, 32'h5555AAAA);
        @(posedge clk_in); #1;
        chk("bp_ready_c2", 32'(req_ready_o), 32'd0);
        chk("bp_resp_c2", 32'({resp_valid_o, resp_err_o}), 32'b10);
        @(posedge clk_in); #1;
        chk("bp_ready_c3", 32'(req_ready_o), 32'd1);
        chk("bp_first_nwr", 32'(wr_cnt - wr0), 32'd1);
        chk("bp_first_nrd", 32'(rd_cnt - rd0), 32'd0);
        rd0 = rd_cnt; wr0 = wr_cnt;
        @(posedge clk_in); #1;
        req_valid_i = 1'b0;
        lat = 1;
        while (!resp_valid_o && lat < 30) begin @(posedge clk_in); #1; lat++; end
        chk_txn("bp_second", lat, resp_rdata_o, resp_err_o, rd_cnt - rd0, wr_cnt - wr0,
                3, 32'h5555AAAA, 1'b0, 1, 0);

        // Reset taken while a byte store sits in its merge cycle
        @(posedge clk_in); #1;
        drive(1'b1, 2'd0, 1'b0, 32'd295217, 32'h00000077);
        wait_ready();
        wr0 = wr_cnt;
        @(posedge clk_in); #1;
        req_valid_i = 1'b0;
        chk("rst_rmw_rden", 32'(data_mem_read_en_o), 32'd1);
        @(posedge clk_in); #1;
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        chk_idle_outputs("rst_mid");
        seen_resp = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk_in); #1;
            seen_resp = seen_resp | resp_valid_o;
        end
        chk("rst_no_resp", 32'(seen_resp), 32'd0);
        chk("rst_no_write", 32'(wr_cnt - wr0), 32'd0);
        model(1'b0, 2'd2, 1'b0, 32'd295216, 32'h0, e_lat, e_rd, e_er, e_nrd, e_nwr);
        run_txn(1'b0, 2'd2, 1'b0, 32'd295216, 32'h0, lat, rd, er, nrd, nwr);
        chk_txn("rst_after_lw", lat, rd, er, nrd, nwr, e_lat, e_rd, e_er, e_nrd, e_nwr);

        // Random traffic, concentrated on a few words to stress read-after-write
        for (int t = 0; t < 300; t++) begin
            r   = int'($urandom_range(0, 9));
            we  = 1'($urandom_range(0, 1));
            sz  = 2'($urandom_range(0, 3));
            uns = 1'($urandom_range(0, 1));
            wd  = $urandom();
            if (r == 0)      a = DM_BASE - $urandom_range(1, 8);
            else if (r == 1) a = DM_BASE + NBYTES + $urandom_range(0, 8);
            else if (r < 7)  a = DM_BASE + $urandom_range(0, 31);
            else             a = DM_BASE + $urandom_range(0, NBYTES - 1);
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            model(we, sz, uns, a, wd, e_lat, e_rd, e_er, e_nrd, e_nwr);
            run_txn(we, sz, uns, a, wd, lat, rd, er, nrd, nwr);
            chk_txn($sformatf("rnd%0d", t), lat, rd, er, nrd, nwr, e_lat, e_rd, e_er, e_nrd, e_nwr);
        end

        @(posedge clk_in); #1;
        for (int w = 0; w < int'(DM_WORDS); w++)
            chk($sformatf("final_mem%0d", w), mem_w[w],
                {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
